// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data cache memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin pick; the port that did not win last time wins a tie.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = req[PORT_D] ? PORT_D : PORT_I;
    if (req == 2'b11) begin
      gnt_idx = ~last;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-wide data memory between the icache (port 0) and dcache (port 1).
// Round-robin grant, request held in registers until the memory acks, then one idle cycle.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              p0_enable_i,
  input  logic              p1_enable_i,
  input  logic              p0_write_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [LINE_W-1:0] p0_data_i,
  input  logic [LINE_W-1:0] p1_data_i,
  output logic              p0_ack_o,
  output logic              p1_ack_o,
  output logic [LINE_W-1:0] p0_data_o,
  output logic [LINE_W-1:0] p1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  arb_state_e state;
  logic       rr_last;
  logic       grant;
  logic       gnt_valid;
  logic       gnt_idx;
  logic       load;

  rr_arb2 u_rr_arb2 (
    .req       ({p1_enable_i, p0_enable_i}),
    .last      (rr_last),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign load = (state == IDLE) && gnt_valid;

  // Control: state, round-robin history, grant owner and memory strobes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      rr_last      <= PORT_D;
      grant        <= PORT_I;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            grant        <= gnt_idx;
            rr_last      <= gnt_idx;
            mem_enable_o <= 1'b1;
            mem_write_o  <= (gnt_idx == PORT_D) ? p1_write_i : p0_write_i;
            state        <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            state        <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Request payload is captured only at grant, so requester changes in BUSY are invisible.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_addr_o <= '0;
      mem_data_o <= '0;
    end else if (load) begin
      mem_addr_o <= (gnt_idx == PORT_D) ? p1_addr_i : p0_addr_i;
      mem_data_o <= (gnt_idx == PORT_D) ? p1_data_i : p0_data_i;
    end
  end

  assign p0_ack_o  = mem_ack_i && (state == BUSY) && (grant == PORT_I);
  assign p1_ack_o  = mem_ack_i && (state == BUSY) && (grant == PORT_D);
  assign p0_data_o = mem_data_i;
  assign p1_data_o = mem_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;

  logic              clk_i;
  logic              rst_n_i;
  logic [1:0]        en;
  logic [1:0]        wr;
  logic [ADDR_W-1:0] ad [2];
  logic [LINE_W-1:0] dt [2];
  logic              p0_ack_o, p1_ack_o;
  logic [LINE_W-1:0] p0_data_o, p1_data_o;
  logic              mem_enable_o, mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;

  int n_vec = 0;
  int n_err = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .p0_enable_i  (en[0]),
    .p1_enable_i  (en[1]),
    .p0_write_i   (wr[0]),
    .p1_write_i   (wr[1]),
    .p0_addr_i    (ad[0]),
    .p1_addr_i    (ad[1]),
    .p0_data_i    (dt[0]),
    .p1_data_i    (dt[1]),
    .p0_ack_o     (p0_ack_o),
    .p1_ack_o     (p1_ack_o),
    .p0_data_o    (p0_data_o),
    .p1_data_o    (p1_data_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chka(input string name, input logic [ADDR_W-1:0] act, input logic [ADDR_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chkl(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < int'(LINE_W / 32); i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr();
    return ADDR_W'($urandom & 32'hFFFF_FFE0);
  endfunction

  // Reference model: one outstanding transaction, next grant allowed two cycles after an ack.
  logic              m_active;
  logic              m_port;
  logic              m_write;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_data;
  logic              m_last;
  int                m_next_ok;
  int                cyc = 0;
  int                n_acks = 0;
  logic [1:0]        ack_seen;
  logic              exp0, exp1;

  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      chk1("rst_mem_enable", mem_enable_o, 1'b0);
      chk1("rst_mem_write", mem_write_o, 1'b0);
      chk1("rst_p0_ack", p0_ack_o, 1'b0);
      chk1("rst_p1_ack", p1_ack_o, 1'b0);
      m_active  = 1'b0;
      m_last    = 1'b1;
      m_next_ok = 0;
      ack_seen  = 2'b00;
    end else begin
      exp0 = mem_ack_i && m_active && !m_port;
      exp1 = mem_ack_i && m_active && m_port;
      chk1("p0_ack", p0_ack_o, exp0);
      chk1("p1_ack", p1_ack_o, exp1);
      chk1("mem_enable", mem_enable_o, m_active);
      chk1("mem_write", mem_write_o, m_active && m_write);
      if (m_active) begin
        chka("mem_addr", mem_addr_o, m_addr);
        chkl("mem_data", mem_data_o, m_data);
      end
      chkl("p0_data", p0_data_o, mem_data_i);
      chkl("p1_data", p1_data_o, mem_data_i);
      ack_seen = {p1_ack_o, p0_ack_o};
      if (p0_ack_o || p1_ack_o) n_acks++;
      if (m_active) begin
        if (mem_ack_i) begin
          m_active  = 1'b0;
          m_next_ok = cyc + 2;
        end
      end else if (cyc >= m_next_ok && en != 2'b00) begin
        m_port   = (en == 2'b11) ? ~m_last : en[1];
        m_write  = wr[m_port];
        m_addr   = ad[m_port];
        m_data   = dt[m_port];
        m_last   = m_port;
        m_active = 1'b1;
      end
    end
    cyc++;
  end

  // Stimulus helpers: memory responder and random requesters.
  logic auto_mem, auto_req;
  logic mem_busy;
  int   mem_cnt;

  task automatic mem_step();
    mem_ack_i = 1'b0;
    if (mem_busy) begin
      if (mem_cnt == 0) begin
        mem_ack_i  = 1'b1;
        mem_data_i = rand_line();
        mem_busy   = 1'b0;
      end else begin
        mem_cnt--;
      end
    end else if (mem_enable_o) begin
      mem_busy = 1'b1;
      mem_cnt  = int'($urandom_range(0, 4));
    end else if ($urandom_range(0, 15) == 0) begin
      mem_ack_i  = 1'b1;
      mem_data_i = rand_line();
    end
  endtask

  task automatic new_req(input int k);
    en[k] = 1'b1;
    wr[k] = 1'($urandom_range(0, 1));
    ad[k] = rand_addr();
    dt[k] = rand_line();
  endtask

  task automatic req_step();
    for (int k = 0; k < 2; k++) begin
      if (ack_seen[k]) begin
        if ($urandom_range(0, 3) == 0) en[k] = 1'b0;
        else new_req(k);
      end else if (!en[k]) begin
        if ($urandom_range(0, 2) == 0) new_req(k);
      end else if (m_active && (int'(m_port) == k) && $urandom_range(0, 7) == 0) begin
        ad[k] = rand_addr();
        dt[k] = rand_line();
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk_i);
    #1;
    if (auto_mem) mem_step();
    if (auto_req) req_step();
  endtask

  task automatic sample();
    @(negedge clk_i);
    #1;
  endtask

  logic [3:0] seq;
  int         got;
  int         gap;

  initial begin
    rst_n_i = 1'b1;
    en = 2'b00; wr = 2'b00;
    ad[0] = '0; ad[1] = '0; dt[0] = '0; dt[1] = '0;
    mem_ack_i = 1'b0; mem_data_i = '0;
    auto_mem = 1'b0; auto_req = 1'b0; mem_busy = 1'b0; mem_cnt = 0;
    seq = 4'b1111; got = 0; gap = 0;
    #1 rst_n_i = 1'b0;
    repeat (3) cycle();
    rst_n_i = 1'b1;
    sample();
    chk1("reset_enable", mem_enable_o, 1'b0);
    chk1("reset_p0_ack", p0_ack_o, 1'b0);
    chk1("reset_p1_ack", p1_ack_o, 1'b0);
    chka("reset_addr", mem_addr_o, 32'h0);

    // Single fill from icache, memory acks ten cycles after the grant.
    cycle();
    en[0] = 1'b1; wr[0] = 1'b0; ad[0] = 32'h0000_0040;
    sample();
    chk1("fill_pre_enable", mem_enable_o, 1'b0);
    cycle();
    sample();
    chk1("fill_enable", mem_enable_o, 1'b1);
    chka("fill_addr", mem_addr_o, 32'h0000_0040);
    chk1("fill_write", mem_write_o, 1'b0);
    repeat (9) cycle();
    mem_ack_i = 1'b1; mem_data_i = {8{32'hA5A5_A5A5}};
    sample();
    chk1("fill_p0_ack", p0_ack_o, 1'b1);
    chk1("fill_p1_ack", p1_ack_o, 1'b0);
    chkl("fill_p0_data", p0_data_o, {8{32'hA5A5_A5A5}});
    cycle();
    mem_ack_i = 1'b0; en[0] = 1'b0;
    sample();
    chk1("fill_gap_enable", mem_enable_o, 1'b0);
    chk1("fill_gap_ack", p0_ack_o, 1'b0);
    cycle();

    // Dirty miss from dcache: write-back then fill with enable held.
    en[1] = 1'b1; wr[1] = 1'b1; ad[1] = 32'h0000_1000; dt[1] = {8{32'hDEAD_BEEF}};
    cycle();
    sample();
    chk1("wb_write", mem_write_o, 1'b1);
    chka("wb_addr", mem_addr_o, 32'h0000_1000);
    chkl("wb_data", mem_data_o, {8{32'hDEAD_BEEF}});
    cycle();
    cycle();
    mem_ack_i = 1'b1;
    sample();
    chk1("wb_ack", p1_ack_o, 1'b1);
    cycle();
    mem_ack_i = 1'b0; wr[1] = 1'b0; ad[1] = 32'h0000_2000;
    gap = 0;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (mem_enable_o) break;
      gap++;
      cycle();
    end
    chka("wb_fill_gap", ADDR_W'(gap), 32'd2);
    chk1("refill_write", mem_write_o, 1'b0);
    chka("refill_addr", mem_addr_o, 32'h0000_2000);
    cycle();
    mem_ack_i = 1'b1;
    sample();
    chk1("refill_ack", p1_ack_o, 1'b1);
    cycle();
    mem_ack_i = 1'b0; en[1] = 1'b0;
    cycle();

    // Contention out of reset with both requests held.
    rst_n_i = 1'b0;
    en = 2'b11; wr = 2'b00; ad[0] = 32'h0000_0100; ad[1] = 32'h0000_0200;
    cycle();
    cycle();
    rst_n_i = 1'b1; mem_busy = 1'b0; auto_mem = 1'b1;
    got = 0;
    for (int i = 0; i < 200 && got < 4; i++) begin
      sample();
      if (p0_ack_o) begin seq[got] = 1'b0; got++; end
      else if (p1_ack_o) begin seq[got] = 1'b1; got++; end
      cycle();
    end
    chka("contention_grants", ADDR_W'(got), 32'd4);
    for (int i = 0; i < 4; i++) chk1("contention_order", seq[i], 1'(i % 2));
    auto_mem = 1'b0; mem_ack_i = 1'b0; en = 2'b00;
    cycle();
    cycle();

    // Stray ack while idle.
    mem_ack_i = 1'b1;
    sample();
    chk1("stray_p0_ack", p0_ack_o, 1'b0);
    chk1("stray_p1_ack", p1_ack_o, 1'b0);
    cycle();
    mem_ack_i = 1'b0;
    sample();
    chk1("stray_enable", mem_enable_o, 1'b0);
    cycle();

    // Reset asserted in the middle of a transaction.
    en[0] = 1'b1; wr[0] = 1'b0; ad[0] = 32'h0000_0080;
    cycle();
    sample();
    chk1("rst_pre_enable", mem_enable_o, 1'b1);
    #1;
    rst_n_i = 1'b0; mem_ack_i = 1'b1; en[0] = 1'b0;
    #1;
    chk1("rst_async_enable", mem_enable_o, 1'b0);
    chk1("rst_drop_ack", p0_ack_o, 1'b0);
    cycle();
    sample();
    cycle();
    rst_n_i = 1'b1; mem_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk1("rst_idle", mem_enable_o, 1'b0);
      cycle();
    end
    en = 2'b11; wr = 2'b00; ad[0] = 32'h0000_0600; ad[1] = 32'h0000_0700;
    cycle();
    sample();
    chk1("rst_prio_enable", mem_enable_o, 1'b1);
    chka("rst_prio_addr", mem_addr_o, 32'h0000_0600);
    cycle();
    mem_ack_i = 1'b1;
    sample();
    chk1("rst_prio_ack", p0_ack_o, 1'b1);
    cycle();
    mem_ack_i = 1'b0; en = 2'b00;
    cycle();
    cycle();

    // Requester changes its address while being served.
    en[0] = 1'b1; wr[0] = 1'b0; ad[0] = 32'h0000_3000;
    cycle();
    sample();
    chka("hold_addr_grant", mem_addr_o, 32'h0000_3000);
    cycle();
    ad[0] = 32'h0000_5000;
    sample();
    chka("hold_addr_busy", mem_addr_o, 32'h0000_3000);
    cycle();
    mem_ack_i = 1'b1;
    sample();
    chk1("hold_ack", p0_ack_o, 1'b1);
    cycle();
    mem_ack_i = 1'b0; en[0] = 1'b0;
    cycle();
    cycle();

    // Randomized traffic with random memory latency and stray acks.
    n_acks = 0;
    mem_busy = 1'b0; auto_mem = 1'b1; auto_req = 1'b1;
    repeat (3000) cycle();
    auto_req = 1'b0; en = 2'b00;
    repeat (30) cycle();
    auto_mem = 1'b0; mem_ack_i = 1'b0;
    cycle();
    sample();
    chk1("rand_progress", n_acks > 100, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single 256-bit-line data memory between the instruction cache (port 0) and the data cache (port 1). It sits between the two cache controllers' memory-side interfaces and the data memory. Each cache sees a private memory with the same enable/write/ack protocol. The arbiter selects the winner round-robin, registers the winning request, holds it until the memory acks, and then inserts one idle cycle before the next grant.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- LINE_W, 256, cache line width in bits

Ports:
- clk_i  in  1  system clock, rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- p0_enable_i, p1_enable_i  in  1  request from icache / dcache; held high until the matching ack
- p0_write_i, p1_write_i  in  1  1 = line write-back, 0 = line fill
- p0_addr_i, p1_addr_i  in  ADDR_W  line address, bits [4:0] = 0
- p0_data_i, p1_data_i  in  LINE_W  write-back data
- p0_ack_o, p1_ack_o  out  1  one-cycle completion pulse to the granted port
- p0_data_o, p1_data_o  out  LINE_W  fill data, valid when the matching ack is high
- mem_enable_o  out  1  request to the data memory
- mem_write_o  out  1  write strobe to the data memory
- mem_addr_o  out  ADDR_W  address to the data memory
- mem_data_o  out  LINE_W  write data to the data memory
- mem_data_i  in  LINE_W  read data from the data memory
- mem_ack_i  in  1  one-cycle completion pulse from the data memory

## Operation
- States are IDLE, BUSY and GAP. On reset: state = IDLE, rr_last = 1 (port 0 has priority first), and all mem_* and p*_ack_o outputs are 0.
- IDLE:
  - If either enable is high, pick the winner.
  - If only one port requests, that port wins.
  - If both request, the port != rr_last wins.
  - On the clock edge: latch grant, write, addr and data from the winner into mem_* registers, set mem_enable_o = 1, set rr_last = winner, and go to BUSY.
  - If neither requests, stay in IDLE with mem_enable_o = 0.
- BUSY:
  - mem_* registers are held stable; requester inputs are ignored.
  - When mem_ack_i = 1: drive p{grant}_ack_o = 1 combinationally in the same cycle. On the edge, clear mem_enable_o and mem_write_o, then go to GAP.
- GAP:
  - Lasts exactly one cycle with mem_enable_o = 0, then goes to IDLE.
  - During this cycle the acked cache updates its enable and write. A write-back followed by a fill from the same cache is seen as a fresh request.
- p0_data_o and p1_data_o are both wired to mem_data_i. Only the ack is gated by grant.
- p{n}_ack_o = mem_ack_i & (state == BUSY) & (grant == n). A mem_ack_i outside BUSY is dropped.
- If a requester drops its enable while in BUSY (a protocol violation), the memory transaction still completes and the ack is still issued.
- mem_addr_o is forwarded unmodified. The arbiter does no address translation or alignment checking.

## Timing
- Request latency: enable seen high in IDLE at cycle t gives mem_enable_o = 1 at t+1.
- Ack pass-through has zero cycles of added latency.
- Back-to-back service: ack at cycle t, GAP at t+1, arbitration in IDLE at t+2, next mem_enable_o at t+3.
- Minimum memory-idle gap between transactions is 2 cycles (GAP plus IDLE). The data memory relies on this gap to restart its latency counter.
- Fairness: when both ports request continuously, grants alternate 0,1,0,1. Maximum wait is one full transaction of the other port plus 3 cycles.
- Reset asserted mid-BUSY:
  - All outputs go to 0 immediately (asynchronously) and state returns to IDLE.
  - A mem_ack_i arriving later is dropped.
- Simultaneous requests arriving exactly as the previous ack arrives are not considered until IDLE.

## Structure
- Package mem_arb_pkg:
  - State encoding localparams: IDLE = 2'd0, BUSY = 2'd1, GAP = 2'd2.
  - Port index constants: PORT_I = 1'b0, PORT_D = 1'b1.
- Sub-module rr_arb2: combinational two-input round-robin pick.
  - Inputs: req[1:0], last.
  - Outputs: gnt_valid, gnt_idx.
  - The sequential rr_last register stays in mem_arbiter.
- Datapath: one set of LINE_W + ADDR_W + 1 request registers, with the load enable asserted only on the IDLE→BUSY edge.

## Test plan
- Single fill: p0 requests addr 0x0000_0040, write = 0; memory acks 10 cycles later with data 0xA5… → mem_addr_o = 0x40 from the next cycle, p0_ack_o pulses once, p0_data_o = 0xA5…, p1_ack_o stays 0.
- Dirty miss from dcache: p1 writes back 0x0000_1000, then fills 0x0000_2000 with enable held high → two transactions separated by exactly two mem_enable_o = 0 cycles. The second transaction has mem_write_o = 0 and mem_addr_o = 0x2000.
- Contention: p0 and p1 both request out of reset → p0 is granted first, then p1. With both requests held, the sequence of grants is 0,1,0,1.
- Stray ack: pulse mem_ack_i while in IDLE → no p*_ack_o and no state change.
- Reset mid-transaction: assert rst_n_i = 0 in BUSY → mem_enable_o = 0 with no clock edge. After release, with no requests pending, the arbiter stays in IDLE and p0 has priority.
- Request-stability check: change p0_addr_i during BUSY → mem_addr_o keeps the value latched at grant.
